// File: rtl/btn_scan_pkg.sv
// Shared types and width helpers for the push-button scan controller.
package btn_scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    COMPARE = 2'd2,
    UPDATE  = 2'd3
  } scan_state_e;

  // Event code layout: button index in the low bits, press flag just above it.
  localparam int EVT_IDX_LSB = 0;

  function automatic int idWidth(input int nBtn);
    return (nBtn <= 2) ? 1 : $clog2(nBtn);
  endfunction

  function automatic int cntWidth(input int stableCnt);
    return $clog2(stableCnt + 1);
  endfunction

  function automatic int evtPressPos(input int nBtn);
    return idWidth(nBtn);
  endfunction

  function automatic int evtWidth(input int nBtn);
    return idWidth(nBtn) + 1;
  endfunction

endpackage

// File: rtl/btn_scan_ctrl_if.sv
// Event drain bus between the scan controller (master) and the CPU register (slave).
interface btn_scan_ctrl_if
  import btn_scan_pkg::*;
#(
  parameter int N_BTN = 4
) ();

  localparam int CODE_W = evtWidth(N_BTN);

  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;
  logic              overflow;
  logic              clear_ovf;

  modport master (
    output evt_valid,
    output evt_code,
    output overflow,
    input  evt_ready,
    input  clear_ovf
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  overflow,
    output evt_ready,
    output clear_ovf
  );

endinterface

// File: rtl/btn_evt_fifo.sv
// Synchronous event FIFO with a registered head; a push into a full queue
// without a simultaneous pop is dropped and reported on o_drop for one cycle.
module btn_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_pushOk;

  assign o_empty  = (r_count == '0);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_pop    = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign w_pushOk = i_push & (~w_full | w_pop);
  assign o_drop   = i_push & w_full & ~w_pop;
  assign o_data   = r_mem[r_rdPtr];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_pushOk) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Round-robin debounce scanner feeding an event FIFO.
// Define BTN_RELEASE_EVENT_EN to also queue release events.
module btn_scan_ctrl
  import btn_scan_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 32,
  parameter int STABLE_CNT = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  btn_scan_ctrl_if.master  evt_if
);

  localparam int ID_W   = idWidth(N_BTN);
  localparam int CODE_W = evtWidth(N_BTN);
  localparam int CNT_W  = cntWidth(STABLE_CNT);
  localparam int PW     = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0] CNT_HIT    = CNT_W'(STABLE_CNT);
  localparam logic [ID_W-1:0]  PTR_LAST   = ID_W'(N_BTN - 1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);

`ifdef BTN_RELEASE_EVENT_EN
  localparam logic REL_EN = 1'b1;
`else
  localparam logic REL_EN = 1'b0;
`endif

  logic [N_BTN-1:0]  r_sync1;
  logic [N_BTN-1:0]  r_sync2;
  logic [PW-1:0]     r_presc;
  logic              w_tick;
  scan_state_e       r_state;
  scan_state_e       w_stateNext;
  logic [ID_W-1:0]   r_ptr;
  logic              r_sample;
  logic [CNT_W-1:0]  r_cnt [N_BTN];
  logic [N_BTN-1:0]  r_btnState;
  logic              w_hit;
  logic              w_push;
  logic [CODE_W-1:0] w_code;
  logic              w_drop;
  logic              w_fifoEmpty;
  logic              r_ovf;

  assign btn_state        = r_btnState;
  assign evt_if.evt_valid = ~w_fifoEmpty;
  assign evt_if.overflow  = r_ovf;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_hit  = (r_cnt[r_ptr] == CNT_HIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The whole visit takes three cycles, so the next tick always finds IDLE.
  always_comb begin
    w_stateNext = r_state;
    w_push      = 1'b0;
    w_code      = '0;
    w_code[EVT_IDX_LSB +: ID_W]   = r_ptr;
    w_code[evtPressPos(N_BTN)]    = r_sample;
    case (r_state)
      IDLE:    if (w_tick) w_stateNext = SAMPLE;
      SAMPLE:  w_stateNext = COMPARE;
      COMPARE: w_stateNext = UPDATE;
      UPDATE: begin
        w_stateNext = IDLE;
        w_push      = w_hit & (r_sample | REL_EN);
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sample   <= 1'b0;
      r_ptr      <= '0;
      r_btnState <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      case (r_state)
        SAMPLE: r_sample <= r_sync2[r_ptr];
        COMPARE: begin
          if (r_sample != r_btnState[r_ptr]) begin
            if (!w_hit) r_cnt[r_ptr] <= r_cnt[r_ptr] + CNT_W'(1);
          end else begin
            r_cnt[r_ptr] <= '0;
          end
        end
        UPDATE: begin
          if (w_hit) begin
            r_btnState[r_ptr] <= r_sample;
            r_cnt[r_ptr]      <= '0;
          end
          r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

  btn_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_code),
    .i_pop   (evt_if.evt_ready),
    .o_data  (evt_if.evt_code),
    .o_empty (w_fifoEmpty),
    .o_drop  (w_drop)
  );

  // A drop in the same cycle as a clear request leaves the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (evt_if.clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Scoreboard bench for btn_scan_ctrl: stimulus pushes expected event codes,
// an independent monitor pops and compares them as the DUT drains events.
module tb_btn_scan_ctrl;
  import btn_scan_pkg::*;

  localparam int N_BTN      = 4;
  localparam int TICK_DIV   = 32;
  localparam int STABLE_CNT = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = idWidth(N_BTN);
  localparam int CODE_W     = ID_W + 1;
  localparam int LAT        = (STABLE_CNT + 1) * N_BTN * TICK_DIV + 5;
`ifdef BTN_RELEASE_EVENT_EN
  localparam bit RELEASE_EN = 1'b1;
`else
  localparam bit RELEASE_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N_BTN-1:0] btnIn = '0;
  logic [N_BTN-1:0] btnState;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [CODE_W-1:0] sbQ [$];
  bit   [N_BTN-1:0]  model  = '0;
  bit                expOvf = 1'b0;

  btn_scan_ctrl_if #(.N_BTN(N_BTN)) evtBus ();

  btn_scan_ctrl #(
    .N_BTN      (N_BTN),
    .TICK_DIV   (TICK_DIV),
    .STABLE_CNT (STABLE_CNT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_in    (btnIn),
    .btn_state (btnState),
    .evt_if    (evtBus)
  );

  always #5 clock = ~clock;

  // Cycle index since the last clock edge that sampled reset high.
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected event.
  always @(negedge clock) begin
    if (!reset && evtBus.evt_valid === 1'b1 && evtBus.evt_ready === 1'b1) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_event: got %0h, expected none", evtBus.evt_code);
      end else begin
        checkOutput("evt_code", 32'(evtBus.evt_code), 32'(sbQ.pop_front()));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic waitDrain(input string name);
    int t = 0;
    while (sbQ.size() != 0 && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    checkOutput(name, sbQ.size(), 0);
    sbQ.delete();
  endtask

  task automatic doReset();
    reset = 1'b1;
    btnIn = '0;
    evtBus.evt_ready = 1'b0;
    evtBus.clear_ovf = 1'b0;
    waitCycles(2);
    reset  = 1'b0;
    model  = '0;
    expOvf = 1'b0;
    sbQ.delete();
  endtask

  function automatic logic [CODE_W-1:0] mkCode(input bit press, input int b);
    logic [ID_W-1:0] idx;
    idx = ID_W'(b);
    return {press, idx};
  endfunction

  // Drive a clean level change and let it settle; queue the event it should cause.
  task automatic applyStimulus(input int b, input bit v);
    btnIn[b] = v;
    if (model[b] != v) begin
      model[b] = v;
      if (v || RELEASE_EN) begin
        if (evtBus.evt_ready == 1'b0 && sbQ.size() == FIFO_DEPTH) expOvf = 1'b1;
        else sbQ.push_back(mkCode(v, b));
      end
    end
    waitCycles(LAT + 8);
  endtask

  // First scan slot visiting button b whose sample is taken at least 4 cycles from now.
  function automatic int nextSlot(input int b, input int c);
    int k = 0;
    while (!((k % N_BTN) == b && (k + 1) * TICK_DIV >= c + 4)) k++;
    return k;
  endfunction

  task automatic pulseClear();
    evtBus.clear_ovf = 1'b1;
    waitCycles(1);
    evtBus.clear_ovf = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int u;
    int b;
    evtBus.evt_ready = 1'b0;
    evtBus.clear_ovf = 1'b0;
    @(posedge clock);
    #1;
    doReset();
    checkOutput("rst_evt_valid", evtBus.evt_valid, 0);
    checkOutput("rst_evt_code", 32'(evtBus.evt_code), 0);
    checkOutput("rst_btn_state", btnState, 0);
    checkOutput("rst_overflow", evtBus.overflow, 0);

    $display("[TB] single steady press");
    evtBus.evt_ready = 1'b1;
    waitCycles(10);
    applyStimulus(2, 1'b1);
    waitDrain("t1_drain");
    checkOutput("t1_btn_state", btnState, model);

    $display("[TB] bouncing button 0");
    for (int i = 0; i < 20; i++) begin
      btnIn[0] = ~btnIn[0];
      waitCycles(100);
    end
    btnIn[0] = 1'b0;
    waitCycles(LAT);
    checkOutput("t2_btn_state", btnState, model);
    checkOutput("t2_evt_valid", evtBus.evt_valid, 0);

    $display("[TB] overflow and clear");
    doReset();
    for (int i = 0; i < N_BTN; i++) applyStimulus(i, 1'b1);
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b1);
    checkOutput("t3_overflow_set", evtBus.overflow, expOvf);
    checkOutput("t3_evt_valid", evtBus.evt_valid, 1);
    pulseClear();
    checkOutput("t3_overflow_clr", evtBus.overflow, 0);
    evtBus.evt_ready = 1'b1;
    waitDrain("t3_drain");
    waitCycles(2);
    checkOutput("t3_empty", evtBus.evt_valid, 0);

    $display("[TB] push into full FIFO with simultaneous pop");
    doReset();
    applyStimulus(0, 1'b1);
    applyStimulus(1, 1'b1);
    applyStimulus(2, 1'b1);
    applyStimulus(0, 1'b0);
`ifndef BTN_RELEASE_EVENT_EN
    applyStimulus(0, 1'b1);
`endif
    checkOutput("t4_full_ovf", evtBus.overflow, 0);
    k = nextSlot(3, cyc);
    btnIn[3] = 1'b1;
    model[3] = 1'b1;
    sbQ.push_back(mkCode(1'b1, 3));
    u = (k + (STABLE_CNT - 1) * N_BTN + 1) * TICK_DIV + 2;
    waitCyc(u);
    evtBus.evt_ready = 1'b1;
    waitCyc(u + 1);
    evtBus.evt_ready = 1'b0;
    checkOutput("t4_evt_valid", evtBus.evt_valid, 1);
    checkOutput("t4_overflow", evtBus.overflow, 0);
    checkOutput("t4_btn_state", btnState, model);
    evtBus.evt_ready = 1'b1;
    waitDrain("t4_drain");
    waitCycles(2);
    checkOutput("t4_empty", evtBus.evt_valid, 0);

    $display("[TB] press then release button 3");
    doReset();
    evtBus.evt_ready = 1'b1;
    applyStimulus(3, 1'b1);
    applyStimulus(3, 1'b0);
    waitDrain("t5_drain");
    checkOutput("t5_btn_state", btnState, 0);

    $display("[TB] reset mid-operation");
    doReset();
    applyStimulus(0, 1'b1);
    applyStimulus(2, 1'b1);
    k = nextSlot(1, cyc);
    btnIn[1] = 1'b1;
    waitCyc((k + N_BTN + 1) * TICK_DIV + 3);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    checkOutput("t6_evt_valid", evtBus.evt_valid, 0);
    checkOutput("t6_btn_state", btnState, 0);
    checkOutput("t6_overflow", evtBus.overflow, 0);
    sbQ.delete();
    model = 4'b0111;
    sbQ.push_back(mkCode(1'b1, 0));
    sbQ.push_back(mkCode(1'b1, 1));
    sbQ.push_back(mkCode(1'b1, 2));
    evtBus.evt_ready = 1'b1;
    waitCyc((1 + (STABLE_CNT - 2) * N_BTN + 1) * TICK_DIV + 4);
    checkOutput("t6_btn1_early", btnState[1], 0);
    waitCyc((1 + (STABLE_CNT - 1) * N_BTN + 1) * TICK_DIV + 4);
    checkOutput("t6_btn1_flip", btnState[1], 1);
    waitCycles(2 * TICK_DIV);
    waitDrain("t6_drain");
    checkOutput("t6_btn_final", btnState, model);

    $display("[TB] randomized glitches and clean toggles");
    doReset();
    for (int it = 0; it < 12; it++) begin
      evtBus.evt_ready = ($urandom_range(0, 3) != 0);
      b = int'($urandom_range(0, N_BTN - 1));
      if ($urandom_range(0, 2) == 0) begin
        btnIn[b] = ~model[b];
        waitCycles(int'($urandom_range(1, 100)));
        btnIn[b] = model[b];
        waitCycles(300);
      end else begin
        applyStimulus(b, ~model[b]);
      end
      checkOutput("rand_btn_state", btnState, model);
      checkOutput("rand_overflow", evtBus.overflow, expOvf);
      if (expOvf && $urandom_range(0, 1) == 1) begin
        pulseClear();
        expOvf = 1'b0;
        checkOutput("rand_ovf_clear", evtBus.overflow, 0);
      end
    end
    evtBus.evt_ready = 1'b1;
    waitDrain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
